// File: rtl/rollo_regfile_acc.sv
// rollo_regfile_acc: R-entry GF(2^M) register file with a multi-beat
// subset-XOR accumulator. Reads and accumulation results share data_out.
// Optional feature: define ROLLO_RF_ZEROIZE_EN to add a 'zeroize' input
// that clears every entry and data_out from IDLE.

// One storage entry plus its contribution to the accumulator. Entry IDX is
// consumed on beat IDX/P, so each entry decides locally whether it feeds the
// XOR tree this cycle.
module rollo_rf_entry #(
  parameter int M    = 67,
  parameter int CW   = 1,
  parameter int BEAT = 0
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          we,
  input  logic          clr,
  input  logic [M-1:0]  d,
  input  logic [CW-1:0] beat,
  input  logic          pick,
  output logic [M-1:0]  q,
  output logic [M-1:0]  term
);

  // entry storage: clear wins over write
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end

  assign term = (pick && (beat == CW'(BEAT))) ? q : '0;

endmodule

module rollo_regfile_acc #(
  parameter int M = 67,
  parameter int R = 5,
  parameter int P = 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
`ifdef ROLLO_RF_ZEROIZE_EN
  input  logic                 zeroize,
`endif
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 acc_start,
  input  logic [$clog2(R)-1:0] addr,
  input  logic [M-1:0]         data_in,
  input  logic [R-1:0]         sel,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_valid,
  output logic [M-1:0]         data_out
);

  localparam int AW = $clog2(R);
  localparam int B  = (R + P - 1) / P;
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t              state;
  logic [CW-1:0]       beat;
  logic [R-1:0]        sel_q;
  logic [M-1:0]        acc;
  logic [R-1:0][M-1:0] ent_q;
  logic [R-1:0][M-1:0] term;
  logic [M-1:0]        acc_term;
  logic [M-1:0]        rd_data;
  logic                idle, addr_ok, zero_go, acc_go, wr_go, rd_go;

  assign idle    = (state == IDLE);
  assign addr_ok = (int'(addr) < R);

`ifdef ROLLO_RF_ZEROIZE_EN
  assign zero_go = idle && zeroize;
`else
  assign zero_go = 1'b0;
`endif

  // only the highest-priority command present acts; an out-of-range
  // address kills its command without letting a lower one through
  assign acc_go = idle && !zero_go && acc_start;
  assign wr_go  = idle && !zero_go && !acc_start && wr_en && addr_ok;
  assign rd_go  = idle && !zero_go && !acc_start && !wr_en && rd_en && addr_ok;

  // entries are write-locked in ACC, so the result equals the contents at start
  for (genvar e = 0; e < R; e++) begin : g_ent
    rollo_rf_entry #(.M(M), .CW(CW), .BEAT(e / P)) u_ent (
      .clk   (clk),
      .rst_b (rst_b),
      .we    (wr_go && (addr == AW'(e))),
      .clr   (zero_go),
      .d     (data_in),
      .beat  (beat),
      .pick  ((state == ACC) && sel_q[R-1-e]),
      .q     (ent_q[e]),
      .term  (term[e])
    );
  end

  // XOR of every entry selected on the current beat
  always_comb begin
    acc_term = '0;
    for (int e = 0; e < R; e++) acc_term = acc_term ^ term[e];
  end

  // read mux; out-of-range addresses never reach data_out
  always_comb begin
    rd_data = '0;
    for (int e = 0; e < R; e++)
      if (addr == AW'(e)) rd_data = ent_q[e];
  end

  // control FSM with registered busy/done/rd_valid/data_out
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      data_out <= '0;
      acc      <= '0;
      beat     <= '0;
      sel_q    <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (zero_go) begin
            data_out <= '0;
          end else if (acc_go) begin
            sel_q <= sel;
            acc   <= '0;
            beat  <= '0;
            state <= ACC;
            busy  <= 1'b1;
          end else if (rd_go) begin
            data_out <= rd_data;
            rd_valid <= 1'b1;
          end
        end
        ACC: begin
          acc <= acc ^ acc_term;
          if (beat == CW'(B - 1)) begin
            data_out <= acc ^ acc_term;
            done     <= 1'b1;
            busy     <= 1'b0;
            beat     <= '0;
            state    <= IDLE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
